// File: rtl/intirvx_wb_arbiter_pkg.sv
// rtl/intirvx_wb_arbiter_pkg.sv - shared types for the Inti RVX write-back arbiter
package intirvx_wb_arbiter_pkg;

  typedef enum logic {
    WB_FIXED = 1'b0,
    WB_RR    = 1'b1
  } wb_arb_mode_e;

  localparam int WB_CNT_W = 32;

endpackage

// File: rtl/intirvx_rr_arbiter.sv
// rtl/intirvx_rr_arbiter.sv - request to one-hot grant, fixed or rotating priority
module intirvx_rr_arbiter
  import intirvx_wb_arbiter_pkg::*;
#(
  parameter int           NCH  = 3,
  parameter wb_arb_mode_e MODE = WB_FIXED,
  localparam int          IW   = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_any
);

  logic [IW-1:0] ptr;

  // Fixed mode searches from 0; round-robin searches from ptr with wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (MODE == WB_RR) ? int'(ptr) + k : k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = IW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == WB_RR && gnt_any) begin
      ptr <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/intirvx_wb_arbiter.sv
// rtl/intirvx_wb_arbiter.sv - NCH-channel write-back arbiter with sticky trap capture
// Optional per-channel acceptance counters under INTIRVX_WB_PERF_EN.
module intirvx_wb_arbiter
  import intirvx_wb_arbiter_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int XLEN     = 32,
  parameter int RFA      = 5,
  parameter int ARB_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NCH-1:0]                ch_valid,
  output logic [NCH-1:0]                ch_ready,
  input  logic [NCH-1:0][XLEN-1:0]      ch_res,
  input  logic [NCH-1:0][RFA-1:0]       ch_rd,
  input  logic [NCH-1:0]                ch_exc,
  input  logic                          flush,
  output logic                          wb_valid,
  output logic [RFA-1:0]                wb_rd,
  output logic [XLEN-1:0]               wb_data,
  output logic                          trap_valid,
  output logic [$clog2(NCH)-1:0]        trap_ch,
`ifdef INTIRVX_WB_PERF_EN
  output logic [NCH-1:0][WB_CNT_W-1:0]  perf_cnt,
`endif
  input  logic                          trap_ack
);

  localparam int IW = $clog2(NCH);

  logic [NCH-1:0] req;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  gnt_idx;
  logic           gnt_any;
  logic           acc_exc;
  logic           acc_wr;

  // Nothing may be accepted while a trap is pending, during flush or reset.
  assign req      = ch_valid & {NCH{~trap_valid & ~flush & ~rst}};
  assign ch_ready = gnt;
  assign acc_exc  = gnt_any && ch_exc[gnt_idx];
  assign acc_wr   = gnt_any && !ch_exc[gnt_idx] && (ch_rd[gnt_idx] != '0);

  intirvx_rr_arbiter #(
    .NCH  (NCH),
    .MODE (ARB_MODE != 0 ? WB_RR : WB_FIXED)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      trap_valid <= 1'b0;
      trap_ch    <= '0;
    end else begin
      wb_valid <= acc_wr;
      if (acc_wr) begin
        wb_rd   <= ch_rd[gnt_idx];
        wb_data <= ch_res[gnt_idx];
      end
      if (acc_exc) begin
        trap_valid <= 1'b1;
        trap_ch    <= gnt_idx;
      end else if (trap_ack && trap_valid) begin
        trap_valid <= 1'b0;
      end
    end
  end

`ifdef INTIRVX_WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (gnt[i] && !ch_exc[i]) perf_cnt[i] <= perf_cnt[i] + WB_CNT_W'(1);
      end
    end
  end
`endif

endmodule
